// File: rtl/reglk_wr_filter.sv
// Register-lock write filter: checks each request against the lock bank,
// forwards allowed ones and records violations.
module reglk_wr_filter #(
    parameter int NUM_WORDS = 6,
    parameter int CNT_W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_WORDS-1:0][31:0] reglk_i,
    input  logic                       jtag_unlock_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_we_i,
    input  logic [7:0]                 req_idx_i,
    input  logic [31:0]                req_wdata_i,
    output logic                       fwd_valid_o,
    input  logic                       fwd_ready_i,
    output logic                       fwd_we_o,
    output logic [7:0]                 fwd_idx_o,
    output logic [31:0]                fwd_wdata_o,
    output logic                       rsp_valid_o,
    output logic                       rsp_err_o,
    output logic                       viol_o,
    output logic [7:0]                 viol_idx_o,
    output logic [CNT_W-1:0]           viol_cnt_o,
    input  logic                       viol_clr_i
);

    typedef enum logic [1:0] {IDLE, CHECK, FWD, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [7:0]        idx_q;
    logic [31:0]       wdata_q;
    logic              err_q, err_d;
    logic              lock_bit;
    logic              in_range;
    logic              blocked;
    logic              accept;
    logic              viol_hit;
    logic              viol_q;
    logic [7:0]        viol_idx_q;
    logic [CNT_W-1:0]  viol_cnt_q;

    assign accept   = req_valid_i && req_ready_o;
    assign in_range = int'({24'd0, idx_q}) < NUM_WORDS * 32;
    assign blocked  = !in_range || (we_q && lock_bit && !jtag_unlock_i);
    assign viol_hit = (state_q == CHECK) && blocked;

    // Live lock-bit lookup for the captured index (sampled in CHECK).
    always_comb begin
        lock_bit = 1'b0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (idx_q[7:5] == w[2:0]) lock_bit = reglk_i[w][idx_q[4:0]];
        end
    end

    // State and error-flag register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic for the request lifecycle.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (req_valid_i) state_d = CHECK;
            CHECK: begin
                state_d = blocked ? RESP : FWD;
                err_d   = blocked;
            end
            FWD: begin
                if (fwd_ready_i) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture on acceptance; held stable while forwarding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we_i;
            idx_q   <= req_idx_i;
            wdata_q <= req_wdata_i;
        end
    end

    // Violation tracking; a new violation beats a simultaneous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            viol_q     <= 1'b0;
            viol_idx_q <= '0;
            viol_cnt_q <= '0;
        end else if (viol_hit) begin
            viol_q <= 1'b1;
            if (viol_clr_i) viol_cnt_q <= CNT_W'(1);
            else if (!(&viol_cnt_q)) viol_cnt_q <= viol_cnt_q + CNT_W'(1);
            if (viol_clr_i || !viol_q) viol_idx_q <= idx_q;
        end else if (viol_clr_i) begin
            viol_q     <= 1'b0;
            viol_idx_q <= '0;
            viol_cnt_q <= '0;
        end
    end

    assign req_ready_o = (state_q == IDLE) && !rst_i;
    assign fwd_valid_o = (state_q == FWD);
    assign fwd_we_o    = fwd_valid_o && we_q;
    assign fwd_idx_o   = fwd_valid_o ? idx_q : 8'd0;
    assign fwd_wdata_o = fwd_valid_o ? wdata_q : 32'd0;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_err_o   = rsp_valid_o && err_q;
    assign viol_o      = viol_q;
    assign viol_idx_o  = viol_idx_q;
    assign viol_cnt_o  = viol_cnt_q;

endmodule
